// File: rtl/mem_pkg.sv
// Shared definitions for the mem_master slice: funct3 codes, FSM states,
// memory op direction constants and the funct3 legality helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_master_if.sv
// Request/response handshake and memory-port bundle for mem_master.
// master = the initiator block, slave = core plus memory side.
interface mem_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_op;
  logic                  mem_rw;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_w;
  logic [DATA_WIDTH-1:0] mem_data_r;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_r,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_op, mem_rw, mem_addr, mem_data_w
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_r,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_op, mem_rw, mem_addr, mem_data_w
  );
endinterface

// File: rtl/mem_master_align.sv
// Combinational load extension (LB/LH/LBU/LHU/LW) and sub-word store merge
// of the low byte/half into a word read back from memory.
module mem_master_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [15:0]           wdata_lo,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged_data
);

  always_comb begin
    load_data = rdata;
    unique case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH-8){rdata[7]}}, rdata[7:0]};
      F3_H:    load_data = {{(DATA_WIDTH-16){rdata[15]}}, rdata[15:0]};
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, rdata[7:0]};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, rdata[15:0]};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merged_data = {rdata[DATA_WIDTH-1:8], wdata_lo[7:0]};
    if (funct3 == F3_H) merged_data = {rdata[DATA_WIDTH-1:16], wdata_lo};
  end

endmodule

// File: rtl/mem_master.sv
// RV32 load/store initiator: single read for loads, read-modify-write for SB/SH.
// Define MEM_MASTER_MISALIGN_CHECK_EN to fault misaligned halfword/word accesses.
module mem_master
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 1024
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  mem_master_if.master  bus
);

  // addr + 3 >= MEM_SIZE rewritten as addr >= MEM_SIZE - 3 to avoid wraparound
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_SIZE - 3);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [15:0]           wlo_q, wlo_d;
  logic                  mem_op_q, mem_op_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_w_q, mem_data_w_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic                  accept;
  logic                  misalign;
  logic                  bad_req;
  logic                  needs_read;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged_data;

  mem_master_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3      (f3_q),
    .rdata       (bus.mem_data_r),
    .wdata_lo    (wlo_q),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  assign accept = bus.req_valid && (state_q == IDLE);

`ifdef MEM_MASTER_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (bus.req_funct3[1:0] == 2'b01) misalign = bus.req_addr[0];
    if (bus.req_funct3[1:0] == 2'b10) misalign = (bus.req_addr[1:0] != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

  assign bad_req = !f3_legal(bus.req_we, bus.req_funct3) ||
                   (bus.req_addr >= ADDR_LIMIT) || misalign;
  assign needs_read = !bus.req_we || (bus.req_funct3 != F3_W);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      wlo_q        <= '0;
      mem_op_q     <= 1'b0;
      mem_rw_q     <= MEM_OP_READ;
      mem_addr_q   <= '0;
      mem_data_w_q <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      wlo_q        <= wlo_d;
      mem_op_q     <= mem_op_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_w_q <= mem_data_w_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad_req)         state_d = ERR;
          else if (needs_read) state_d = RD;
          else                 state_d = WR;
        end
      end
      RD:      state_d = we_q ? WR : IDLE;
      WR:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d         = we_q;
    f3_d         = f3_q;
    wlo_d        = wlo_q;
    mem_op_d     = 1'b0;
    mem_rw_d     = MEM_OP_READ;
    mem_addr_d   = mem_addr_q;
    mem_data_w_d = mem_data_w_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d       = bus.req_we;
          f3_d       = bus.req_funct3;
          wlo_d      = bus.req_wdata[15:0];
          mem_addr_d = bus.req_addr;
          if (!bad_req) begin
            mem_op_d = 1'b1;
            if (!needs_read) begin
              mem_rw_d     = MEM_OP_WRITE;
              mem_data_w_d = bus.req_wdata;
            end
          end
        end
      end
      RD: begin
        if (we_q) begin
          mem_op_d     = 1'b1;
          mem_rw_d     = MEM_OP_WRITE;
          mem_data_w_d = merged_data;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end
      WR: resp_valid_d = 1'b1;
      ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_op     = mem_op_q;
  assign bus.mem_rw     = mem_rw_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data_w = mem_data_w_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed and random load/store sequences against a byte-level reference
// memory; the bench also plays the negedge-sampling data memory.
module tb_mem_master;

  logic clk;
  logic rst_n;

  mem_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(1024)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus.master)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  mem     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  int          rd_cnt;
  int          wr_cnt;
  int          phase_viol;
  logic [31:0] last_wdata;
  logic [31:0] last_waddr;
  logic        prev_op;
  logic        prev_rw;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: samples op on negedge, writes 4 bytes, returns read word.
  always @(negedge clk) begin
    if (bus.mem_op) begin
      if (prev_op && (prev_rw == bus.mem_rw)) phase_viol++;
      if (bus.mem_rw) begin
        for (int i = 0; i < 4; i++)
          mem[(int'(bus.mem_addr) + i) & 1023] = bus.mem_data_w[8*i +: 8];
        last_wdata = bus.mem_data_w;
        last_waddr = bus.mem_addr;
        wr_cnt++;
      end else begin
        for (int i = 0; i < 4; i++)
          bus.mem_data_r[8*i +: 8] = mem[(int'(bus.mem_addr) + i) & 1023];
        rd_cnt++;
      end
    end
    prev_op = bus.mem_op;
    prev_rw = bus.mem_rw;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit we, input bit [2:0] f3, input int unsigned addr,
                        input logic [31:0] wdata, output logic [31:0] got);
    int          nbytes;
    bit          err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    longint      v;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wword;
    int          lat;

    nbytes = ((f3 & 3'd3) == 0) ? 1 : ((f3 & 3'd3) == 1) ? 2 : 4;
    err = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (longint'(addr) + 3 >= 1024) err = 1'b1;
`ifdef MEM_MASTER_MISALIGN_CHECK_EN
    if ((addr % nbytes) != 0) err = 1'b1;
`endif
    exp_rdata = '0;
    exp_wword = '0;
    if (err) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!we) begin
      exp_lat = 1; exp_rd = 1; exp_wr = 0;
      v = 0;
      for (int i = 0; i < nbytes; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
      if (!f3[2] && nbytes < 4 && v >= (64'sd1 << (8 * nbytes - 1)))
        v -= (64'sd1 << (8 * nbytes));
      exp_rdata = v[31:0];
    end else begin
      exp_lat = (nbytes < 4) ? 2 : 1;
      exp_rd  = (nbytes < 4) ? 1 : 0;
      exp_wr  = 1;
      for (int i = 0; i < 4; i++)
        exp_wword[8*i +: 8] = (i < nbytes) ? wdata[8*i +: 8] : ref_mem[addr + i];
      for (int i = 0; i < nbytes; i++) ref_mem[addr + i] = wdata[8*i +: 8];
    end

    @(negedge clk);
    rd_cnt = 0;
    wr_cnt = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("first_op", {31'd0, bus.mem_op}, {31'd0, !err});
    if (!err) begin
      check("first_rw", {31'd0, bus.mem_rw}, {31'd0, (we && nbytes == 4)});
      check("first_addr", bus.mem_addr, addr);
    end
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) begin
        lat = c;
        break;
      end
    end
    got = bus.resp_rdata;
    check("latency", lat, exp_lat);
    check("resp_err", {31'd0, bus.resp_err}, {31'd0, err});
    check("resp_rdata", bus.resp_rdata, exp_rdata);
    check("req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rd_count", rd_cnt, exp_rd);
    check("wr_count", wr_cnt, exp_wr);
    if (!err && we) begin
      check("wr_word", last_wdata, exp_wword);
      check("wr_addr", last_waddr, addr);
      for (int i = 0; i < 4; i++)
        check("mem_byte", {24'd0, mem[addr + i]}, {24'd0, ref_mem[addr + i]});
    end
    @(posedge clk);
    #1;
    check("resp_pulse", {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int unsigned addr;
    bit          we;
    bit [2:0]    f3;
    int          seen_resp;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    rd_cnt = 0; wr_cnt = 0; phase_viol = 0;
    last_wdata = '0; last_waddr = '0;
    prev_op = 1'b0; prev_rw = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_data_r = '0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_mem_op", {31'd0, bus.mem_op}, 32'd0);
    check("rst_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_data_w", bus.mem_data_w, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle_mem_op", {31'd0, bus.mem_op}, 32'd0);
    end

    // Word store then load
    do_req(1'b1, 3'b010, 32'h10, 32'h12345678, r);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, r);
    check("lw_0x10", r, 32'h12345678);

    // Byte stores and signed/unsigned loads
    do_req(1'b1, 3'b000, 32'h20, 32'h00000080, r);
    do_req(1'b1, 3'b000, 32'h21, 32'h0000007F, r);
    do_req(1'b0, 3'b000, 32'h20, 32'h0, r);
    check("lb_0x20", r, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h20, 32'h0, r);
    check("lbu_0x20", r, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h20, 32'h0, r);
    check("lh_0x20", r, 32'h00007F80);

    // Unaligned RMW byte store
    do_req(1'b1, 3'b000, 32'h11, 32'h000000AB, r);
    check("sb_merge_word", last_wdata, 32'h001234AB);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, r);
    check("lw_after_sb", r, 32'h1234AB78);

    // Bounds, illegal funct3, misalignment
    do_req(1'b0, 3'b010, 32'h3FE, 32'h0, r);
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0, r);
    do_req(1'b0, 3'b000, 32'h3FD, 32'h0, r);
    do_req(1'b0, 3'b011, 32'h40, 32'h0, r);
    do_req(1'b1, 3'b100, 32'h40, 32'h55, r);
    do_req(1'b0, 3'b001, 32'h11, 32'h0, r);
    do_req(1'b1, 3'b001, 32'h31, 32'h0000BEEF, r);

    // Reset during the read phase of an RMW
    @(negedge clk);
    rd_cnt = 0;
    wr_cnt = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h000000CD;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rmw_rd_op", {31'd0, bus.mem_op}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_op", {31'd0, bus.mem_op}, 32'd0);
    seen_resp = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) seen_resp++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) seen_resp++;
    end
    check("rst_no_resp", seen_resp, 0);
    check("rst_no_write", wr_cnt, 0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, r);
    check("lw_after_rst", r, 32'h1234AB78);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr = ($urandom_range(0, 9) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 63);
      do_req(we, f3, addr, $urandom, r);
    end

    check("phase_violations", phase_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
